logic_unit_serial: RTL and testbench

- Parametrised, multi-cycle bitwise logic unit for the MiniMIPS datapath.
- Generalises the 32-bit combinational inverter to WIDTH bits and five operations: NOT, AND, OR, XOR, NOR.
- Processes operands in SLICE-bit chunks, one chunk per clock, using a start/busy/done handshake.
- Trades latency for area in the multi-cycle ALU path.

---
 rtl/logic_unit_defs.sv | 30 +++
 rtl/logic_slice.sv | 30 +++
 rtl/logic_unit_serial.sv | 127 ++++++++++++
 tb/tb_logic_unit_serial.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_defs.sv
// Shared definitions for the serial bitwise logic unit: op codes, FSM state
// encoding and the per-slice operator function.
package logic_unit_defs;

  // Operation codes carried on the op port; 101-111 are not assigned.
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when the op code names one of the five implemented operations.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_NOR);
  endfunction

  // Counter width for a given slice count, never narrower than one bit.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator. Illegal op codes produce an
// all-zero output and raise the illegal flag. Shared with any full-width
// combinational variant of the logic unit.
module logic_slice
  import logic_unit_defs::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y,
  output logic             illegal
);

  // Select the bitwise function; b is a don't-care for NOT.
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit. Operands are latched on an accepted start,
// then one SLICE-bit chunk is computed per clock into a working register.
// The full result, zero and illegal flags are published only on entry to
// DONE, so partial results never appear on the outputs.
module logic_unit_serial
  import logic_unit_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  // Refuse to elaborate a slicing that leaves a partial chunk.
  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("logic_unit_serial: SLICE must divide WIDTH exactly");
  end

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;

  logic [SLICE-1:0] a_sel;
  logic [SLICE-1:0] b_sel;
  logic [SLICE-1:0] slice_y;
  logic             slice_illegal;
  logic [WIDTH-1:0] work_next;
  logic             accept;

  // Chunk selection from the latched operands, driven by the slice counter.
  always_comb begin
    a_sel = a_reg[int'(cnt_reg) * SLICE +: SLICE];
    b_sel = b_reg[int'(cnt_reg) * SLICE +: SLICE];
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op      (op_reg),
    .a       (a_sel),
    .b       (b_sel),
    .y       (slice_y),
    .illegal (slice_illegal)
  );

  // Working register with the current chunk replaced by the slice output;
  // this is what gets stored each RUN cycle and published after the last.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_merge
    assign work_next[gi*SLICE +: SLICE] =
      (cnt_reg == CW'(gi)) ? slice_y : work_reg[gi*SLICE +: SLICE];
  end

  // A new request is taken from IDLE or, back-to-back, from DONE.
  assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // Controller: operand capture, per-slice sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NOT;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            cnt_reg   <= '0;
            work_reg  <= '0;
            busy      <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          work_reg <= work_next;
          if (cnt_reg == LAST_CNT) begin
            // The op is constant for the whole run, so the last slice's
            // illegal flag speaks for the entire operation.
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= slice_illegal ? '0 : work_next;
            zero      <= slice_illegal || (work_next == '0);
            illegal   <= slice_illegal;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
// Directed-vector bench for logic_unit_serial: a default 32/8 instance and
// a 16/4 instance. Inputs change and outputs are sampled on the falling edge.
module tb_logic_unit_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  logic        start_n;
  logic [2:0]  op_n;
  logic [15:0] a_n;
  logic [15:0] b_n;
  logic        busy_n;
  logic        done_n;
  logic [15:0] result_n;
  logic        zero_n;
  logic        illegal_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_serial dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .illegal (illegal)
  );

  logic_unit_serial #(
    .WIDTH (16),
    .SLICE (4)
  ) dut_n (
    .clk     (clk),
    .reset   (reset),
    .start   (start_n),
    .op      (op_n),
    .a       (a_n),
    .b       (b_n),
    .busy    (busy_n),
    .done    (done_n),
    .result  (result_n),
    .zero    (zero_n),
    .illegal (illegal_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present a request for one clock; returns in the first cycle after E0.
  task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; k0 is the cycle index after E0 on entry.
  task automatic wait_done(input int k0, input logic [31:0] hold,
                           output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = k0; k <= k0 + 20; k++) begin
      if (k == 3) check("hold_during_run", result, hold);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  int lat;
  int bcnt;
  int done_seen;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'b000;
    a       = '0;
    b       = '0;
    start_n = 1'b0;
    op_n    = 3'b000;
    a_n     = '0;
    b_n     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_result",  result,           32'd0);
    check("rst_zero",    {31'd0, zero},    32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // NOT
    start_op(3'b000, 32'hF000F000, 32'h12345678);
    wait_done(1, 32'h0, lat, bcnt);
    check("not_latency", lat, 5);
    check("not_busy_cycles", bcnt, 4);
    check("not_result", result, 32'h0FFF0FFF);
    check("not_zero", {31'd0, zero}, 32'd0);
    check("not_illegal", {31'd0, illegal}, 32'd0);
    check("not_busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("not_done_single", {31'd0, done}, 32'd0);
    check("not_result_held", result, 32'h0FFF0FFF);

    // AND
    start_op(3'b001, 32'hFFFF0000, 32'h0F0F0F0F);
    wait_done(1, 32'h0FFF0FFF, lat, bcnt);
    check("and_latency", lat, 5);
    check("and_result", result, 32'h0F0F0000);
    check("and_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);

    // XOR to zero
    start_op(3'b011, 32'hAAAAAAAA, 32'hAAAAAAAA);
    wait_done(1, 32'h0F0F0000, lat, bcnt);
    check("xor_latency", lat, 5);
    check("xor_result", result, 32'h0);
    check("xor_zero", {31'd0, zero}, 32'd1);
    check("xor_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);

    // Back-to-back: start held through RUN and DONE
    op    = 3'b010;
    a     = 32'hAAAAAAAA;
    b     = 32'h55555555;
    start = 1'b1;
    @(negedge clk);
    wait_done(1, 32'h0, lat, bcnt);
    check("b2b_first_latency", lat, 5);
    check("b2b_first_result", result, 32'hFFFFFFFF);
    op = 3'b001;
    a  = 32'hFFFFFFFF;
    b  = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    wait_done(1, 32'hFFFFFFFF, lat, bcnt);
    check("b2b_second_latency", lat, 5);
    check("b2b_second_result", result, 32'h12345678);
    @(negedge clk);

    // Start pulsed with new operands mid-RUN is ignored
    start_op(3'b001, 32'h12345678, 32'hFF00FF00);
    @(negedge clk);
    op    = 3'b100;
    a     = 32'h0;
    b     = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, 32'h12345678, lat, bcnt);
    check("midrun_latency", lat, 5);
    check("midrun_result", result, 32'h12005600);
    @(negedge clk);
    check("midrun_not_queued", {31'd0, busy}, 32'd0);

    // Illegal op
    start_op(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, 32'h12005600, lat, bcnt);
    check("ill_latency", lat, 5);
    check("ill_result", result, 32'h0);
    check("ill_zero", {31'd0, zero}, 32'd1);
    check("ill_illegal", {31'd0, illegal}, 32'd1);
    @(negedge clk);

    // Produce a non-zero result, then abort a run with reset in cycle 2
    start_op(3'b000, 32'h0000FFFF, 32'h0);
    wait_done(1, 32'h0, lat, bcnt);
    check("pre_abort_result", result, 32'hFFFF0000);
    @(negedge clk);
    start_op(3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'h0);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);

    // NOR after abort
    start_op(3'b100, 32'h0, 32'h0);
    wait_done(1, 32'h0, lat, bcnt);
    check("nor_latency", lat, 5);
    check("nor_result", result, 32'hFFFFFFFF);
    @(negedge clk);

    // 16-bit / 4-bit slice instance: NOR
    op_n    = 3'b100;
    a_n     = 16'hF0F0;
    b_n     = 16'h0F00;
    start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done_n) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("w16_latency", lat, 5);
    check("w16_result", {16'd0, result_n}, 32'h0000000F);
    check("w16_zero", {31'd0, zero_n}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
